div_seq: RTL and testbench

- Iterative 32-bit radix-2 restoring divider with its own sequencing FSM, for DIV/DIVU in the EX stage.
- EX raises start_i with the operands and holds it. The block asserts stallreq_o into the pipeline stall controller until the result is ready.
- It returns {remainder, quotient} for the HI/LO write.
- annul_i lets a flush abandon an in-flight divide.

---
 rtl/div_seq_pkg.sv | 23 ++
 rtl/div_seq_if.sv | 32 +++
 rtl/div_step.sv | 34 +++
 rtl/div_seq.sv | 138 +++++++++++++
 tb/tb_div_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared constants and state encoding for the sequential divider
//
// Purpose: state encoding, handshake level names and result width used by
// div_seq and its step datapath.
// Ports: none (package).

package div_seq_pkg;

  localparam int DIV_RES_WD = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - EX-stage to divider handshake bundle
//
// Purpose: groups the divide request, operands and result/stall handshake.
// Signals (named from the divider's side):
//   start_i, annul_i, signed_i, opdata1_i, opdata2_i : request from EX
//   result_o {rem, quot}, ready_o, stallreq_o        : response to EX / stall bus
// Modports: master = EX side, slave = divider side.

interface div_seq_if #(
  parameter int DATA_W = 32
) ();

  logic                start_i;
  logic                annul_i;
  logic                signed_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                stallreq_o;

  modport master (
    output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring iteration (shift + trial subtract)
//
// Purpose: combinational single step of the restoring divider.
// Ports:
//   shreg_i   in  2*DATA_W  {partial remainder, remaining dividend/quotient bits}
//   divisor_i in  DATA_W    divisor magnitude
//   shreg_o   out 2*DATA_W  register contents after the step

module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] shreg_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W-1:0] shreg_o
);

  // Upper W+1 bits of the conceptual (2W+1)-bit register after the left
  // shift. Between steps the partial remainder is below the divisor, so the
  // bit above the stored 2W bits is always zero and need not be kept.
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   trial;
  logic              q_bit;
  logic [DATA_W-1:0] rem_new;

  always_comb begin
    rem_sh  = shreg_i[2*DATA_W-1:DATA_W-1];
    trial   = rem_sh - {1'b0, divisor_i};
    // Non-negative trial difference: keep it and record a 1 quotient bit.
    q_bit   = ~trial[DATA_W];
    rem_new = q_bit ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    shreg_o = {rem_new, shreg_i[DATA_W-2:0], q_bit};
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative restoring DIV/DIVU unit with its own sequencing FSM
//
// Purpose: accepts a divide from EX, runs DATA_W restoring steps (or a short
// divide-by-zero path), and returns {remainder, quotient} with ready_o,
// stalling the pipeline via stallreq_o meanwhile.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   div_bus     div_seq_if.slave (start/annul/signed/operands in,
//               result/ready/stallreq out)

module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_RES_WD / 2,
  parameter int CNT_W  = 6
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave div_bus
);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                qsign_q, qsign_d;
  logic                rsign_q, rsign_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  logic [2*DATA_W-1:0] step_res;
  logic [DATA_W-1:0]   mag1, mag2;
  logic                sign1, sign2;
  logic [DATA_W-1:0]   quot_fin, rem_fin;

  div_step #(.DATA_W(DATA_W)) u_step (
    .shreg_i   (shreg_q),
    .divisor_i (divisor_q),
    .shreg_o   (step_res)
  );

  // Operand signs only matter for DIV; DIVU treats operands as raw magnitudes.
  // The most negative value negates to itself, which is the correct unsigned
  // magnitude, so signed overflow wraps with no special case.
  always_comb begin
    sign1 = div_bus.signed_i & div_bus.opdata1_i[DATA_W-1];
    sign2 = div_bus.signed_i & div_bus.opdata2_i[DATA_W-1];
    mag1  = sign1 ? -div_bus.opdata1_i : div_bus.opdata1_i;
    mag2  = sign2 ? -div_bus.opdata2_i : div_bus.opdata2_i;
  end

  // Sign correction applied to the output of the final step.
  always_comb begin
    quot_fin = qsign_q ? -step_res[DATA_W-1:0] : step_res[DATA_W-1:0];
    rem_fin  = rsign_q ? -step_res[2*DATA_W-1:DATA_W] : step_res[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    divisor_d = divisor_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    result_d  = result_q;

    case (state_q)
      DivFree: begin
        if (div_bus.start_i == DivStart && !div_bus.annul_i) begin
          shreg_d   = {{DATA_W{1'b0}}, mag1};
          divisor_d = mag2;
          qsign_d   = sign1 ^ sign2;
          rsign_d   = sign1;
          cnt_d     = '0;
          state_d   = (div_bus.opdata2_i == '0) ? DivByZero : DivOn;
        end
      end

      DivByZero: begin
        if (div_bus.annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
        end
      end

      DivOn: begin
        if (div_bus.annul_i) begin
          state_d = DivFree;
        end else begin
          shreg_d = step_res;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = DivEnd;
            result_d = {rem_fin, quot_fin};
          end
        end
      end

      DivEnd: begin
        // Holding start keeps the result presented; EX must drop start for
        // a cycle before the next divide can be accepted from DivFree.
        if (div_bus.annul_i || div_bus.start_i == DivStop) begin
          state_d = DivFree;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      shreg_q   <= '0;
      divisor_q <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      divisor_q <= divisor_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      result_q  <= result_d;
    end
  end

  assign div_bus.result_o   = result_q;
  assign div_bus.ready_o    = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
  assign div_bus.stallreq_o = div_bus.start_i & ~div_bus.annul_i &
                              (div_bus.ready_o == DivResultNotReady);

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard testbench for div_seq

module tb_div_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_seq_if #(.DATA_W(32)) div_bus ();

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (div_bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called 1ns after a negedge; drives the request immediately.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input int hold);
    int cyc;
    logic [63:0] got;
    div_bus.start_i   = 1'b1;
    div_bus.annul_i   = 1'b0;
    div_bus.signed_i  = sgn;
    div_bus.opdata1_i = a;
    div_bus.opdata2_i = b;
    exp_q.push_back(model(sgn, a, b));
    cyc = 0;
    #1;
    while (div_bus.ready_o !== 1'b1 && cyc < 100) begin
      check("stall_busy", {63'd0, div_bus.stallreq_o}, 64'd1);
      if (cyc == 1) begin
        div_bus.opdata1_i = $urandom;
        div_bus.opdata2_i = $urandom;
        div_bus.signed_i  = ~sgn;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    check("stall_ready", {63'd0, div_bus.stallreq_o}, 64'd0);
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      check("result", div_bus.result_o, exp_q.pop_front());
    end
    got = div_bus.result_o;
    repeat (hold) begin
      @(negedge clk);
      #1;
      check("hold_ready", {63'd0, div_bus.ready_o}, 64'd1);
      check("hold_result", div_bus.result_o, got);
    end
    div_bus.start_i = 1'b0;
    @(negedge clk);
    #1;
    check("drop_ready", {63'd0, div_bus.ready_o}, 64'd0);
    check("drop_result", div_bus.result_o, got);
  endtask

  initial begin
    int seen;
    rst               = 1'b1;
    div_bus.start_i   = 1'b0;
    div_bus.annul_i   = 1'b0;
    div_bus.signed_i  = 1'b0;
    div_bus.opdata1_i = '0;
    div_bus.opdata2_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {63'd0, div_bus.ready_o}, 64'd0);
    check("rst_result", div_bus.result_o, 64'd0);
    check("rst_stall", {63'd0, div_bus.stallreq_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // DIVU 100/7 with explicit expected value as well as the model
    run_div(1'b0, 32'd100, 32'd7, 33, 0);
    check("divu_100_7", div_bus.result_o, {32'h2, 32'hE});
    run_div(1'b1, 32'hFFFF_FFF9, 32'h2, 33, 0);
    check("div_m7_2", div_bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(1'b1, 32'h7, 32'hFFFF_FFFE, 33, 0);
    check("div_7_m2", div_bus.result_o, {32'h1, 32'hFFFF_FFFD});
    run_div(1'b1, 32'd5, 32'd0, 2, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 0);
    check("div_ovf", div_bus.result_o, {32'h0, 32'h8000_0000});
    run_div(1'b0, 32'hFFFF_FFFF, 32'h1, 33, 0);
    for (int i = 0; i < 4; i++) begin
      run_div(i[0], $urandom, $urandom_range(1, 1000), 33, 0);
    end

    // annul in IDLE blocks acceptance
    div_bus.start_i   = 1'b1;
    div_bus.annul_i   = 1'b1;
    div_bus.signed_i  = 1'b0;
    div_bus.opdata1_i = 32'd50;
    div_bus.opdata2_i = 32'd0;
    seen = 0;
    repeat (3) begin
      #1;
      if (div_bus.ready_o === 1'b1 || div_bus.stallreq_o === 1'b1) seen++;
      @(negedge clk);
    end
    check("annul_idle", 64'(seen), 64'd0);
    div_bus.start_i = 1'b0;
    div_bus.annul_i = 1'b0;
    @(negedge clk);

    // annul in BUSY cycle 10
    div_bus.start_i   = 1'b1;
    div_bus.opdata1_i = 32'd1000;
    div_bus.opdata2_i = 32'd3;
    repeat (10) @(negedge clk);
    div_bus.annul_i = 1'b1;
    #1;
    check("annul_stall", {63'd0, div_bus.stallreq_o}, 64'd0);
    @(negedge clk);
    div_bus.annul_i = 1'b0;
    div_bus.start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      #1;
      if (div_bus.ready_o !== 1'b0) seen++;
      @(negedge clk);
    end
    check("annul_busy", 64'(seen), 64'd0);
    #1;
    run_div(1'b0, 32'd9, 32'd3, 33, 0);
    check("divu_9_3", div_bus.result_o, {32'h0, 32'h3});

    // reset mid-divide
    div_bus.start_i   = 1'b1;
    div_bus.signed_i  = 1'b0;
    div_bus.opdata1_i = 32'd12345;
    div_bus.opdata2_i = 32'd17;
    repeat (15) @(negedge clk);
    rst             = 1'b1;
    div_bus.start_i = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_ready", {63'd0, div_bus.ready_o}, 64'd0);
    check("mid_rst_result", div_bus.result_o, 64'd0);
    check("mid_rst_stall", {63'd0, div_bus.stallreq_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // hold past ready, then immediate restart
    run_div(1'b1, 32'hFFFF_FF9C, 32'd9, 33, 3);
    run_div(1'b0, 32'd77, 32'd5, 33, 0);
    run_div(1'b1, 32'd5, 32'd0, 2, 2);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
